// File: rtl/ram_pkg.sv
// Shared widths, FSM state encoding and response tag type for the RAM initiator.
package ram_pkg;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 4;
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Travels alongside each issued read until its word appears on ram_q.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/ram_rsp_pipe.sv
// Delays read tags by the RAM latency so they line up with ram_q, then registers
// the aligned word and tags as the response stream.
module ram_rsp_pipe #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int RD_LAT = ram_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_q,
  output logic              o_rsp_valid,
  output logic              o_rsp_last,
  output logic [DATA_W-1:0] o_rsp_data
);
  import ram_pkg::*;

  tag_t              r_tag [RD_LAT];
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic [DATA_W-1:0] r_rsp_data;
  tag_t              w_tag_out;

  assign w_tag_out = r_tag[RD_LAT-1];

  // NOTE: the tag shift register is reset element by element because a stale
  // valid bit would emit a phantom response after an abort; the data path only
  // loads under a valid tag, so it needs no clearing beyond the output register.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift behaves as a true pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_tag[0] <= '{valid: i_valid, last: i_last};
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
      r_rsp_valid <= w_tag_out.valid;
      r_rsp_last  <= w_tag_out.valid & w_tag_out.last;
      if (w_tag_out.valid) r_rsp_data <= i_q;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_last  = r_rsp_last;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: rtl/ram_master.sv
// Initiator for the single-port RAM: accepts write / burst-read commands and
// sequences them onto the RAM port, returning read words as a response stream.
module ram_master #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int LEN_W  = ram_pkg::LEN_W,
  parameter int RD_LAT = ram_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);
  import ram_pkg::*;

  state_t            r_state,       w_state_nxt;
  logic [ADDR_W-1:0] r_ram_address, w_ram_address_nxt;
  logic [DATA_W-1:0] r_ram_data,    w_ram_data_nxt;
  logic              r_ram_wren,    w_ram_wren_nxt;
  logic              r_ram_rden,    w_ram_rden_nxt;
  logic              r_cmd_ready,   w_cmd_ready_nxt;
  logic              r_busy,        w_busy_nxt;
  logic [LEN_W-1:0]  r_len_cnt,     w_len_cnt_nxt;

  logic              w_issue_last;
  logic              w_rsp_valid;
  logic              w_rsp_last;
  logic [DATA_W-1:0] w_rsp_data;

  // r_len_cnt counts the issue cycles still to follow the current one.
  assign w_issue_last = (r_state == ST_READ) && (r_len_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_rden    <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_len_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data    <= w_ram_data_nxt;
      r_ram_wren    <= w_ram_wren_nxt;
      r_ram_rden    <= w_ram_rden_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_len_cnt     <= w_len_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_ram_address_nxt = r_ram_address;
    w_ram_data_nxt    = r_ram_data;
    w_ram_wren_nxt    = 1'b0;
    w_ram_rden_nxt    = 1'b0;
    w_len_cnt_nxt     = r_len_cnt;
    w_cmd_ready_nxt   = 1'b0;
    w_busy_nxt        = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
        if (cmd_valid && r_cmd_ready) begin
          w_ram_address_nxt = cmd_addr;
          w_cmd_ready_nxt   = 1'b0;
          w_busy_nxt        = 1'b1;
          if (cmd_we) begin
            w_state_nxt    = ST_WRITE;
            w_ram_wren_nxt = 1'b1;
            w_ram_data_nxt = cmd_wdata;
          end else begin
            w_state_nxt    = ST_READ;
            w_ram_rden_nxt = 1'b1;
            w_len_cnt_nxt  = cmd_len;
          end
        end
      end

      ST_WRITE: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end

      ST_READ: begin
        if (r_len_cnt == '0) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_ram_rden_nxt    = 1'b1;
          w_ram_address_nxt = r_ram_address + ADDR_W'(1);
          w_len_cnt_nxt     = r_len_cnt - LEN_W'(1);
        end
      end

      ST_DRAIN: begin
        // Leave as the final word is on the response port so ready rises next cycle.
        if (w_rsp_valid && w_rsp_last) begin
          w_state_nxt     = ST_IDLE;
          w_cmd_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  ram_rsp_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (r_ram_rden),
    .i_last      (w_issue_last),
    .i_q         (ram_q),
    .o_rsp_valid (w_rsp_valid),
    .o_rsp_last  (w_rsp_last),
    .o_rsp_data  (w_rsp_data)
  );

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign ram_rden    = r_ram_rden;
  assign rsp_valid   = w_rsp_valid;
  assign rsp_last    = w_rsp_last;
  assign rsp_data    = w_rsp_data;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench: three ram_master instances (RD_LAT 1, 2, 4) each driving its own
// RAM model; events are logged per cycle and checked against hand-derived timing.
module tb_ram_master;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [13:0] data;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cmd_valid = '0;
  logic        cmd_we = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [13:0] cmd_wdata = '0;

  logic [2:0]  cmd_ready, rsp_valid, rsp_last, busy, ram_wren, ram_rden;
  logic [13:0] rsp_data    [3];
  logic [11:0] ram_address [3];
  logic [13:0] ram_data    [3];
  logic [13:0] ram_q       [3];

  logic [13:0] mem [3][4096];
  logic [13:0] qp  [3][4];

  ev_t rq [3][$];
  ev_t iq0[$];
  ev_t wq0[$];

  int cyc       = 0;
  int both_high = 0;
  int n_assert  = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  ram_master #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]),
    .busy(busy[0]), .ram_address(ram_address[0]), .ram_data(ram_data[0]),
    .ram_wren(ram_wren[0]), .ram_rden(ram_rden[0]), .ram_q(ram_q[0])
  );

  ram_master #(.RD_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]),
    .busy(busy[1]), .ram_address(ram_address[1]), .ram_data(ram_data[1]),
    .ram_wren(ram_wren[1]), .ram_rden(ram_rden[1]), .ram_q(ram_q[1])
  );

  ram_master #(.RD_LAT(4)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .rsp_last(rsp_last[2]),
    .busy(busy[2]), .ram_address(ram_address[2]), .ram_data(ram_data[2]),
    .ram_wren(ram_wren[2]), .ram_rden(ram_rden[2]), .ram_q(ram_q[2])
  );

  // RAM models: stage 0 holds the word in cycle N+1; stage L-1 in cycle N+L.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (ram_wren[d]) mem[d][ram_address[d]] <= ram_data[d];
      qp[d][0] <= ram_rden[d] ? mem[d][ram_address[d]] : 14'h2AA;
      for (int k = 1; k < 4; k++) qp[d][k] <= qp[d][k-1];
    end
  end

  assign ram_q[0] = qp[0][0];
  assign ram_q[1] = qp[1][1];
  assign ram_q[2] = qp[2][3];

  always @(negedge clk) begin : monitor
    ev_t e;
    for (int d = 0; d < 3; d++) begin
      if (rsp_valid[d]) begin
        e.cyc = cyc; e.addr = '0; e.data = rsp_data[d]; e.last = rsp_last[d];
        rq[d].push_back(e);
      end
      if (ram_rden[d] && ram_wren[d]) both_high++;
    end
    if (ram_rden[0]) begin
      e.cyc = cyc; e.addr = ram_address[0]; e.data = '0; e.last = 1'b0;
      iq0.push_back(e);
    end
    if (ram_wren[0]) begin
      e.cyc = cyc; e.addr = ram_address[0]; e.data = ram_data[0]; e.last = 1'b0;
      wq0.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command to the masked instances; t_acc is the first cycle after acceptance.
  task automatic send(input logic [2:0] mask, input logic we, input logic [11:0] addr,
                      input logic [3:0] len, input logic [13:0] wd, output int t_acc);
    logic [2:0] pend;
    logic [2:0] took;
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_wdata = wd;
    pend = mask; cmd_valid = mask; t_acc = -1;
    for (int i = 0; i < 400 && pend != 3'b000; i++) begin
      took = cmd_valid & cmd_ready;
      step();
      if (took != 3'b000) begin
        pend      = pend & ~took;
        cmd_valid = cmd_valid & ~took;
        if (pend == 3'b000) t_acc = cyc;
      end
    end
    chk("accept_pending", {29'd0, pend}, 32'd0);
    cmd_valid = '0;
  endtask

  task automatic wait_idle(input logic [2:0] mask);
    for (int i = 0; i < 200 && ((cmd_ready & mask) != mask); i++) step();
    chk("idle_wait", {29'd0, cmd_ready & mask}, {29'd0, mask});
  endtask

  task automatic check_burst(input int d, input int base, input int t, input int lat,
                             input logic [13:0] d0, input int n);
    chk($sformatf("rsp%0d_count", d), rq[d].size() - base, n);
    for (int i = 0; i < n && base + i < rq[d].size(); i++) begin
      chk($sformatf("rsp%0d_cyc_%0d", d, i), rq[d][base+i].cyc, t + lat + 1 + i);
      chk($sformatf("rsp%0d_data_%0d", d, i), {18'd0, rq[d][base+i].data}, 32'(d0) + i);
      chk($sformatf("rsp%0d_last_%0d", d, i), {31'd0, rq[d][base+i].last}, (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic check_issue(input int base, input int t, input logic [11:0] a0, input int n);
    logic [11:0] a;
    chk("issue_count", iq0.size() - base, n);
    for (int i = 0; i < n && base + i < iq0.size(); i++) begin
      a = a0 + 12'(i);
      chk($sformatf("issue_cyc_%0d", i), iq0[base+i].cyc, t + i);
      chk($sformatf("issue_addr_%0d", i), {20'd0, iq0[base+i].addr}, {20'd0, a});
    end
  endtask

  initial begin
    int t, t2, base_r, base_i, base_w, n_late;
    logic [11:0] a;

    // Reset state on every instance.
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready%0d", d), {31'd0, cmd_ready[d]}, 32'd1);
      chk($sformatf("rst_busy%0d", d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("rst_strobes%0d", d), {30'd0, ram_wren[d], ram_rden[d]}, 32'd0);
      chk($sformatf("rst_rsp%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
    end
    chk("rst_addr0", {20'd0, ram_address[0]}, 32'd0);
    rst = 1'b0;
    step();

    // Single write: one wren cycle at address 4 with data 3.
    base_w = wq0.size();
    send(3'b001, 1'b1, 12'd4, 4'd0, 14'd3, t);
    chk("wr_wren", {31'd0, ram_wren[0]}, 32'd1);
    chk("wr_addr", {20'd0, ram_address[0]}, 32'd4);
    chk("wr_data", {18'd0, ram_data[0]}, 32'd3);
    chk("wr_ready_low", {31'd0, cmd_ready[0]}, 32'd0);
    chk("wr_busy", {31'd0, busy[0]}, 32'd1);
    step();
    chk("wr_wren_done", {31'd0, ram_wren[0]}, 32'd0);
    chk("wr_ready_back", {31'd0, cmd_ready[0]}, 32'd1);
    chk("wr_count", wq0.size() - base_w, 1);

    // Read it back: response 3 cycles after the accept cycle (t-1).
    base_r = rq[0].size();
    send(3'b001, 1'b0, 12'd4, 4'd0, 14'd0, t);
    wait_idle(3'b001);
    check_burst(0, base_r, t, 1, 14'd3, 1);
    if (rq[0].size() > base_r)
      chk("ready_after_last", cyc, rq[0][base_r].cyc + 1);

    // Preload 10..13 on all instances and FFE..001 on instance 0.
    for (int i = 0; i < 4; i++) begin
      send(3'b111, 1'b1, 12'(10 + i), 4'd0, 14'h100 + 14'(i), t);
      wait_idle(3'b111);
    end
    for (int i = 0; i < 4; i++) begin
      a = 12'hFFE + 12'(i);
      send(3'b001, 1'b1, a, 4'd0, 14'h200 + 14'(i), t);
      wait_idle(3'b001);
    end

    // Four-word burst.
    base_r = rq[0].size(); base_i = iq0.size();
    send(3'b001, 1'b0, 12'd10, 4'd3, 14'd0, t);
    wait_idle(3'b001);
    check_issue(base_i, t, 12'd10, 4);
    check_burst(0, base_r, t, 1, 14'h100, 4);

    // Address wrap past 0xFFF.
    base_r = rq[0].size(); base_i = iq0.size();
    send(3'b001, 1'b0, 12'hFFE, 4'd3, 14'd0, t);
    wait_idle(3'b001);
    check_issue(base_i, t, 12'hFFE, 4);
    check_burst(0, base_r, t, 1, 14'h200, 4);

    // Command held during a len=7 burst is taken only after rsp_last.
    base_r = rq[0].size(); base_w = wq0.size();
    send(3'b001, 1'b0, 12'd10, 4'd7, 14'd0, t);
    send(3'b001, 1'b1, 12'd30, 4'd0, 14'h055, t2);
    chk("busy_rsp_count", rq[0].size() - base_r, 8);
    if (rq[0].size() > base_r) begin
      chk("busy_last_cyc", rq[0][rq[0].size()-1].cyc, t + 9);
      chk("busy_last_flag", {31'd0, rq[0][rq[0].size()-1].last}, 32'd1);
    end
    chk("busy_accept_cyc", t2, t + 11);
    repeat (5) step();
    chk("busy_wr_count", wq0.size() - base_w, 1);
    if (wq0.size() > base_w) begin
      chk("busy_wr_cyc", wq0[base_w].cyc, t2);
      chk("busy_wr_addr", {20'd0, wq0[base_w].addr}, 32'd30);
      chk("busy_wr_data", {18'd0, wq0[base_w].data}, 32'h55);
    end

    // Reset during the third issue cycle of a len=7 read.
    send(3'b001, 1'b0, 12'd40, 4'd7, 14'd0, t);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", {31'd0, cmd_ready[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_strobes", {30'd0, ram_wren[0], ram_rden[0]}, 32'd0);
    chk("abort_rsp", {30'd0, rsp_valid[0], rsp_last[0]}, 32'd0);
    chk("abort_rsp_data", {18'd0, rsp_data[0]}, 32'd0);
    chk("abort_addr", {20'd0, ram_address[0]}, 32'd0);
    chk("abort_data", {18'd0, ram_data[0]}, 32'd0);
    repeat (12) step();
    n_late = 0;
    foreach (rq[0][i]) if (rq[0][i].cyc >= t + 3) n_late++;
    foreach (iq0[i]) if (iq0[i].cyc >= t + 3) n_late++;
    chk("abort_no_late_events", n_late, 0);

    // Latency sweep on the RD_LAT=2 and RD_LAT=4 instances.
    base_r = rq[1].size();
    base_i = rq[2].size();
    send(3'b110, 1'b0, 12'd10, 4'd3, 14'd0, t);
    wait_idle(3'b110);
    check_burst(1, base_r, t, 2, 14'h100, 4);
    check_burst(2, base_i, t, 4, 14'h100, 4);

    chk("rden_wren_exclusive", both_high, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
